// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer.
// Handles load-use, multi-cycle mul/div, data-bus freeze and wrong-path fetch squash.
// All outputs are combinational from the inputs and the two small FSMs.
module hazard_ctrl #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MULDIV_LAT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ibus_busy,
    input  logic             ibus_resp,
    input  logic             dbus_busy,
    input  logic             ex_redirect,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             md_start,
    output logic             pc_stall,
    output logic             stallF,
    output logic             flushF,
    output logic             stallD,
    output logic             flushD,
    output logic             stallE,
    output logic             flushE,
    output logic             flushM,
    output logic             fetch_drop,
    output logic             md_done
);

    localparam int unsigned CNT_W = $clog2(MULDIV_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MULDIV_LAT - 1);

    typedef enum logic {F_RUN, F_DROP} fetch_state_e;
    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    fetch_state_e     fetch_q, fetch_d;
    md_state_e        md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic md_busy;
    logic md_done_c;
    logic md_hold;
    logic load_use;
    logic fetch_wait;
    logic redirect_eff;

    // Hazard terms shared by the FSMs and the stall/flush decode
    always_comb begin
        md_busy      = (md_q == MD_BUSY);
        md_done_c    = md_busy && (cnt_q == '0) && !dbus_busy;
        md_hold      = md_busy && !md_done_c;
        load_use     = ex_is_load && (ex_rd != '0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        fetch_wait   = (ibus_busy && !ibus_resp) || (fetch_q == F_DROP);
        // A redirect frozen behind dbus or mul/div is taken once the freeze lifts
        redirect_eff = ex_redirect && !dbus_busy && !md_hold;
    end

    // State registers for fetch FSM, mul/div FSM and latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_q <= F_RUN;
            md_q    <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            fetch_q <= fetch_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic for both FSMs and the saturating down-counter
    always_comb begin
        fetch_d = fetch_q;
        md_d    = md_q;
        cnt_d   = cnt_q;

        unique case (fetch_q)
            F_RUN: begin
                if (redirect_eff && ibus_busy && !ibus_resp) begin
                    fetch_d = F_DROP;
                end
            end
            F_DROP: begin
                if (ibus_resp) begin
                    fetch_d = F_RUN;
                end
            end
            default: fetch_d = F_RUN;
        endcase

        unique case (md_q)
            MD_IDLE: begin
                if (md_start) begin
                    md_d  = MD_BUSY;
                    cnt_d = CNT_INIT;
                end
            end
            MD_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                if (md_done_c) begin
                    md_d = MD_IDLE;
                end
            end
            default: md_d = MD_IDLE;
        endcase
    end

    // Prioritised stall/flush decode; reset forces every output low
    always_comb begin
        pc_stall   = 1'b0;
        stallF     = 1'b0;
        flushF     = 1'b0;
        stallD     = 1'b0;
        flushD     = 1'b0;
        stallE     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        fetch_drop = 1'b0;
        md_done    = 1'b0;

        if (!reset) begin
            if (dbus_busy) begin
                pc_stall = 1'b1;
                stallF   = 1'b1;
                stallD   = 1'b1;
                stallE   = 1'b1;
                flushM   = 1'b1;
            end else if (md_hold) begin
                pc_stall = 1'b1;
                stallF   = 1'b1;
                stallD   = 1'b1;
                flushE   = 1'b1;
            end else if (redirect_eff) begin
                flushF   = 1'b1;
                flushD   = 1'b1;
            end else if (load_use) begin
                pc_stall = 1'b1;
                stallF   = 1'b1;
                flushD   = 1'b1;
            end else if (fetch_wait) begin
                pc_stall = 1'b1;
                flushF   = 1'b1;
            end

            // Flush outranks stall on the same pipeline register
            stallF = stallF && !flushF;
            stallD = stallD && !flushD;
            stallE = stallE && !flushE;

            fetch_drop = (fetch_q == F_DROP) ||
                         (redirect_eff && ibus_resp);
            md_done    = md_done_c;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table vectors plus multi-cycle sequences for hazard_ctrl.
module tb_hazard_ctrl;

    // Output vector order: pc_stall stallF flushF stallD flushD stallE flushE flushM fetch_drop md_done
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_LU   = 10'b1100100000;
    localparam logic [9:0] O_FW   = 10'b1010000000;
    localparam logic [9:0] O_RD   = 10'b0010100000;
    localparam logic [9:0] O_RDFD = 10'b0010100010;
    localparam logic [9:0] O_DB   = 10'b1101010100;
    localparam logic [9:0] O_MDS  = 10'b1101001000;
    localparam logic [9:0] O_MDD  = 10'b0000000001;
    localparam logic [9:0] O_FD   = 10'b1010000010;

    logic       clk = 1'b0;
    logic       reset;
    logic       ibus_busy, ibus_resp, dbus_busy, ex_redirect, ex_is_load, md_start;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       pc_stall, stallF, flushF, stallD, flushD, stallE, flushE, flushM;
    logic       fetch_drop, md_done;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.REG_W(5), .MULDIV_LAT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ibus_busy  (ibus_busy),
        .ibus_resp  (ibus_resp),
        .dbus_busy  (dbus_busy),
        .ex_redirect(ex_redirect),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .md_start   (md_start),
        .pc_stall   (pc_stall),
        .stallF     (stallF),
        .flushF     (flushF),
        .stallD     (stallD),
        .flushD     (flushD),
        .stallE     (stallE),
        .flushE     (flushE),
        .flushM     (flushM),
        .fetch_drop (fetch_drop),
        .md_done    (md_done)
    );

    always #5 clk = ~clk;

    // Illegal stimulus guard: nothing may start or redirect while mul/div is busy
    always @(posedge clk) begin
        if (!reset && dut.md_busy) begin
            assert (!(md_start || ex_redirect))
                else $error("illegal md_start/ex_redirect during mul/div");
        end
    end

    typedef struct {
        logic       dbus;
        logic       ib;
        logic       ir;
        logic       redir;
        logic       load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [9:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[14];

    task automatic set_in(input logic dbus, input logic ib, input logic ir,
                          input logic redir, input logic load, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic mds);
        dbus_busy   = dbus;
        ibus_busy   = ib;
        ibus_resp   = ir;
        ex_redirect = redir;
        ex_is_load  = load;
        ex_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        md_start    = mds;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {pc_stall, stallF, flushF, stallD, flushD, stallE, flushE, flushM,
               fetch_drop, md_done};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Sample mid-cycle, then advance to just past the next rising edge
    task automatic check_step(input string name, input logic [9:0] exp);
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_NONE, "idle"};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, O_LU,   "lu_rs2"};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd2, O_LU,   "lu_rs1"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, O_NONE, "lu_x0"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, O_NONE, "no_load"};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd3, 5'd4, O_NONE, "lu_nomatch"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_FW,   "fetch_wait"};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_NONE, "fetch_resp"};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, O_LU,   "lu_over_fw"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, O_RDFD, "redir_resp"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 5'd0, O_RD,   "redir_over_lu"};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, O_DB,   "dbus"};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, O_DB,   "dbus_over_lu"};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, O_DB,   "dbus_over_redir"};

        // Reset: outputs forced low even with busy inputs
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        check("reset_gate", O_NONE);
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_step("post_reset", O_NONE);

        // Single-cycle table in idle FSM states
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].dbus, vecs[i].ib, vecs[i].ir, vecs[i].redir, vecs[i].load,
                   vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 1'b0);
            check_step(vecs[i].name, vecs[i].exp);
        end
        idle_in();
        check_step("table_idle", O_NONE);

        // Load-use gives one bubble, then the EX bubble clears it
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0);
        check_step("lu_bubble", O_LU);
        idle_in();
        check_step("lu_after", O_NONE);

        // Redirect with fetch in flight, re-redirect while dropping
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("drop_redir", O_RD);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("drop_wait1", O_FD);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("drop_reredir", O_RDFD);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("drop_wait3", O_FD);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("drop_resp", O_FD);
        idle_in();
        check_step("drop_done", O_NONE);

        // Mul/div: 3 stall cycles then done
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_step("md_start", O_NONE);
        idle_in();
        for (int i = 0; i < 3; i++) check_step("md_stall", O_MDS);
        check_step("md_done", O_MDD);
        check_step("md_idle", O_NONE);

        // Mul/div with dbus held over count 0: done waits, counter saturates
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_step("md2_start", O_NONE);
        idle_in();
        for (int i = 0; i < 3; i++) check_step("md2_stall", O_MDS);
        dbus_busy = 1'b1;
        check_step("md2_dbus0", O_DB);
        check_step("md2_dbus1", O_DB);
        dbus_busy = 1'b0;
        check_step("md2_done", O_MDD);
        check_step("md2_idle", O_NONE);

        // dbus freeze masks redirect and load-use until it drops
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
        check_step("frz_dbus", O_DB);
        dbus_busy = 1'b0;
        check_step("frz_release", O_RD);
        idle_in();
        check_step("frz_idle", O_NONE);

        // Reset mid mul/div (count 2): abandoned, no md_done
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check_step("rmd_start", O_NONE);
        idle_in();
        check_step("rmd_cnt3", O_MDS);
        #1;
        check("rmd_cnt2", O_MDS);
        reset = 1'b1;
        #1;
        check("rmd_reset", O_NONE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) check_step("rmd_after", O_NONE);

        // Reset mid drop: next in-flight response is not discarded
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("rfd_redir", O_RD);
        ex_redirect = 1'b0;
        #1;
        check("rfd_drop", O_FD);
        reset = 1'b1;
        #1;
        check("rfd_reset", O_NONE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_step("rfd_wait", O_FW);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check_step("rfd_resp", O_NONE);
        idle_in();
        check_step("rfd_idle", O_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
